// File: rtl/wb_video_regs_if.sv
// ============================================================================
// Module   : wb_video_regs_if
// Purpose  : Wishbone slave bus bundle for the video register block.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wb_video_regs_if;
    logic [7:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic       wb_we_i;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_video_regs.sv
// ============================================================================
// Module   : wb_video_regs
// Purpose  : Wishbone video control registers with vsync-committed shadows.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_video_regs #(
    parameter logic [7:0] VERSION      = 8'h03,
    parameter logic [1:0] DEFAULT_MODE = 2'd3,
    parameter int         CURSOR_W     = 12
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    wb_video_regs_if.slave           wb,
    input  wire logic                vsync_i,
    output logic [1:0]               pattern_mode_o,
    output logic [7:0]               scroll_x_o,
    output logic [7:0]               scroll_y_o,
    output logic [CURSOR_W-1:0]      cursor_addr_o,
    output logic                     irq_o
);

    localparam logic [3:0] ADR_MODE    = 4'h0;
    localparam logic [3:0] ADR_VERSION = 4'h1;
    localparam logic [3:0] ADR_CTRL    = 4'h2;
    localparam logic [3:0] ADR_STATUS  = 4'h3;
    localparam logic [3:0] ADR_SCX     = 4'h4;
    localparam logic [3:0] ADR_SCY     = 4'h5;
    localparam logic [3:0] ADR_CUR_LO  = 4'h6;
    localparam logic [3:0] ADR_CUR_HI  = 4'h7;
    localparam logic [3:0] ADR_FCNT    = 4'h8;

    logic                ack_q, ack_d;
    logic [7:0]          dat_q, dat_d;
    logic [1:0]          mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
    logic [7:0]          scx_sh_q, scx_sh_d, scx_act_q, scx_act_d;
    logic [7:0]          scy_sh_q, scy_sh_d, scy_act_q, scy_act_d;
    logic [CURSOR_W-1:0] cur_sh_q, cur_sh_d, cur_act_q, cur_act_d;
    logic                shadow_en_q, shadow_en_d, irq_en_q, irq_en_d;
    logic                pending_q, pending_d, frame_irq_q, frame_irq_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                vsync_prev_q, vsync_prev_d, irq_q, irq_d;

    logic       accept, wr, shadow_wr, vs_edge, commit;
    logic [3:0] addr;
    logic [7:0] rd_data;
    logic       unused_adr_hi;

    assign unused_adr_hi = ^wb.wb_adr_i[7:4];

    always_comb begin
        addr      = wb.wb_adr_i[3:0];
        accept    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        wr        = accept & wb.wb_we_i;
        shadow_wr = wr & (addr inside {ADR_MODE, ADR_SCX, ADR_SCY, ADR_CUR_LO, ADR_CUR_HI});
        vs_edge   = vsync_i & ~vsync_prev_q;
        commit    = ~shadow_en_q | (vs_edge & pending_q);

        case (addr)
            ADR_MODE:    rd_data = {6'b0, mode_sh_q};
            ADR_VERSION: rd_data = VERSION;
            ADR_CTRL:    rd_data = {6'b0, irq_en_q, shadow_en_q};
            ADR_STATUS:  rd_data = {6'b0, pending_q, frame_irq_q};
            ADR_SCX:     rd_data = scx_sh_q;
            ADR_SCY:     rd_data = scy_sh_q;
            ADR_CUR_LO:  rd_data = cur_sh_q[7:0];
            ADR_CUR_HI:  rd_data = 8'(cur_sh_q[CURSOR_W-1:8]);
            ADR_FCNT:    rd_data = frame_cnt_q;
            default:     rd_data = 8'h00;
        endcase

        ack_d        = accept;
        dat_d        = (accept & ~wb.wb_we_i) ? rd_data : dat_q;
        mode_sh_d    = mode_sh_q;
        scx_sh_d     = scx_sh_q;
        scy_sh_d     = scy_sh_q;
        cur_sh_d     = cur_sh_q;
        shadow_en_d  = shadow_en_q;
        irq_en_d     = irq_en_q;

        if (wr) begin
            case (addr)
                ADR_MODE:   mode_sh_d = wb.wb_dat_i[1:0];
                ADR_CTRL: begin
                    shadow_en_d = wb.wb_dat_i[0];
                    irq_en_d    = wb.wb_dat_i[1];
                end
                ADR_SCX:    scx_sh_d = wb.wb_dat_i;
                ADR_SCY:    scy_sh_d = wb.wb_dat_i;
                ADR_CUR_LO: cur_sh_d[7:0] = wb.wb_dat_i;
                ADR_CUR_HI: cur_sh_d[CURSOR_W-1:8] = wb.wb_dat_i[CURSOR_W-9:0];
                default: ;
            endcase
        end

        // Commit samples the shadows before this cycle's write lands.
        mode_act_d = commit ? mode_sh_q : mode_act_q;
        scx_act_d  = commit ? scx_sh_q  : scx_act_q;
        scy_act_d  = commit ? scy_sh_q  : scy_act_q;
        cur_act_d  = commit ? cur_sh_q  : cur_act_q;

        if (~shadow_en_q)
            pending_d = 1'b0;
        else if (shadow_wr)
            pending_d = 1'b1;
        else if (vs_edge)
            pending_d = 1'b0;
        else
            pending_d = pending_q;

        frame_irq_d = frame_irq_q;
        if (wr && addr == ADR_STATUS && wb.wb_dat_i[0])
            frame_irq_d = 1'b0;
        if (vs_edge)
            frame_irq_d = 1'b1;

        frame_cnt_d  = vs_edge ? frame_cnt_q + 8'd1 : frame_cnt_q;
        vsync_prev_d = vsync_i;
        irq_d        = frame_irq_q & irq_en_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= 1'b0;
            dat_q        <= 8'h00;
            mode_sh_q    <= DEFAULT_MODE;
            mode_act_q   <= DEFAULT_MODE;
            scx_sh_q     <= 8'h00;
            scx_act_q    <= 8'h00;
            scy_sh_q     <= 8'h00;
            scy_act_q    <= 8'h00;
            cur_sh_q     <= '0;
            cur_act_q    <= '0;
            shadow_en_q  <= 1'b1;
            irq_en_q     <= 1'b0;
            pending_q    <= 1'b0;
            frame_irq_q  <= 1'b0;
            frame_cnt_q  <= 8'h00;
            vsync_prev_q <= 1'b1;
            irq_q        <= 1'b0;
        end else begin
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            mode_sh_q    <= mode_sh_d;
            mode_act_q   <= mode_act_d;
            scx_sh_q     <= scx_sh_d;
            scx_act_q    <= scx_act_d;
            scy_sh_q     <= scy_sh_d;
            scy_act_q    <= scy_act_d;
            cur_sh_q     <= cur_sh_d;
            cur_act_q    <= cur_act_d;
            shadow_en_q  <= shadow_en_d;
            irq_en_q     <= irq_en_d;
            pending_q    <= pending_d;
            frame_irq_q  <= frame_irq_d;
            frame_cnt_q  <= frame_cnt_d;
            vsync_prev_q <= vsync_prev_d;
            irq_q        <= irq_d;
        end
    end

    assign wb.wb_ack_o    = ack_q;
    assign wb.wb_dat_o    = dat_q;
    assign pattern_mode_o = mode_act_q;
    assign scroll_x_o     = scx_act_q;
    assign scroll_y_o     = scy_act_q;
    assign cursor_addr_o  = cur_act_q;
    assign irq_o          = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_video_regs.sv
// ============================================================================
// Module   : tb_wb_video_regs
// Purpose  : Randomized scoreboard bench for wb_video_regs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_video_regs;
    localparam int CW      = 12;
    localparam int HI_MASK = (1 << (CW - 8)) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync_i = 1'b0;
    logic [1:0]    pattern_mode_o;
    logic [7:0]    scroll_x_o, scroll_y_o;
    logic [CW-1:0] cursor_addr_o;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    wb_video_regs_if bus();

    wb_video_regs #(.VERSION(8'h03), .DEFAULT_MODE(2'd3), .CURSOR_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb             (bus),
        .vsync_i        (vsync_i),
        .pattern_mode_o (pattern_mode_o),
        .scroll_x_o     (scroll_x_o),
        .scroll_y_o     (scroll_y_o),
        .cursor_addr_o  (cursor_addr_o),
        .irq_o          (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: register file as byte arrays indexed by offset.
    logic [7:0] m_sh  [0:7];
    logic [7:0] m_act [0:7];
    logic       m_sen, m_ien, m_pend, m_firq, m_irq, m_ack, m_vprev;
    logic [7:0] m_cnt, m_rd;
    logic [7:0] exp_q [$];

    logic       t_acc, t_we, t_edge, t_commit, t_pend, t_firq, t_irq;
    logic [3:0] t_a;
    logic [7:0] t_d;

    function automatic bit is_shadowed(logic [3:0] a);
        return (a == 4'h0) || (a == 4'h4) || (a == 4'h5) || (a == 4'h6) || (a == 4'h7);
    endfunction

    function automatic logic [7:0] model_read(logic [3:0] a);
        case (a)
            4'h0, 4'h4, 4'h5, 4'h6, 4'h7: return m_sh[a[2:0]];
            4'h1: return 8'h03;
            4'h2: return {6'b0, m_ien, m_sen};
            4'h3: return {6'b0, m_pend, m_firq};
            4'h8: return m_cnt;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_sh[i]  = 8'h00;
                m_act[i] = 8'h00;
            end
            m_sh[0]  = 8'h03;
            m_act[0] = 8'h03;
            m_sen = 1'b1; m_ien = 1'b0; m_pend = 1'b0; m_firq = 1'b0;
            m_irq = 1'b0; m_ack = 1'b0; m_vprev = 1'b1;
            m_cnt = 8'h00; m_rd = 8'h00;
            exp_q.delete();
        end else begin
            t_acc    = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
            t_we     = bus.wb_we_i;
            t_a      = bus.wb_adr_i[3:0];
            t_d      = bus.wb_dat_i;
            t_edge   = vsync_i && !m_vprev;
            t_commit = !m_sen || (t_edge && m_pend);

            if (t_acc && !t_we) m_rd = model_read(t_a);
            if (t_acc) exp_q.push_back(m_rd);

            t_irq  = m_firq && m_ien;
            t_pend = !m_sen ? 1'b0 : (t_acc && t_we && is_shadowed(t_a)) ? 1'b1
                   : t_edge ? 1'b0 : m_pend;
            t_firq = t_edge ? 1'b1 : (t_acc && t_we && t_a == 4'h3 && t_d[0]) ? 1'b0 : m_firq;
            if (t_edge) m_cnt = m_cnt + 8'd1;

            if (t_commit)
                for (int i = 0; i < 8; i++)
                    if (is_shadowed(4'(i))) m_act[i] = m_sh[i];

            if (t_acc && t_we) begin
                case (t_a)
                    4'h0: m_sh[0] = t_d & 8'h03;
                    4'h2: begin m_sen = t_d[0]; m_ien = t_d[1]; end
                    4'h4, 4'h5, 4'h6: m_sh[t_a[2:0]] = t_d;
                    4'h7: m_sh[7] = t_d & 8'(HI_MASK);
                    default: ;
                endcase
            end

            m_pend  = t_pend;
            m_firq  = t_firq;
            m_irq   = t_irq;
            m_ack   = t_acc;
            m_vprev = vsync_i;
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: outputs every cycle, read data popped from the scoreboard on ack.
    logic [7:0] exp_dat;
    always @(negedge clk) begin
        chk("ack", int'(bus.wb_ack_o), int'(m_ack));
        if (rst_n && bus.wb_ack_o) begin
            if (exp_q.size() == 0) begin
                chk("ack_without_request", 1, 0);
            end else begin
                exp_dat = exp_q.pop_front();
                chk("dat_o", int'(bus.wb_dat_o), int'(exp_dat));
            end
        end
        if (!rst_n) chk("dat_o_reset", int'(bus.wb_dat_o), 0);
        chk("pattern_mode", int'(pattern_mode_o), int'(m_act[0][1:0]));
        chk("scroll_x", int'(scroll_x_o), int'(m_act[4]));
        chk("scroll_y", int'(scroll_y_o), int'(m_act[5]));
        chk("cursor", int'(cursor_addr_o), int'({m_act[7][CW-9:0], m_act[6]}));
        chk("irq", int'(irq_o), int'(m_irq));
    end

    bit vs_run = 1'b0;
    always @(negedge clk)
        if (vs_run && ($urandom_range(0, 3) == 0)) vsync_i = ~vsync_i;

    task automatic idle();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 8'h00; bus.wb_dat_i = 8'h00;
    endtask

    task automatic xfer(input bit we, input logic [7:0] adr, input logic [7:0] dat,
                        input int hold);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr; bus.wb_dat_i = dat;
        repeat (hold) @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    task automatic rand_traffic(input int n);
        logic [7:0] adr, dat;
        for (int i = 0; i < n; i++) begin
            adr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            dat = 8'($urandom);
            xfer(1'($urandom), adr, dat, $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 8'h00, 8'h00, 1);
        xfer(1'b0, 8'h01, 8'h00, 1);
        xfer(1'b0, 8'h02, 8'h00, 1);
        xfer(1'b1, 8'h04, 8'h20, 1);
        xfer(1'b0, 8'h03, 8'h00, 1);
        vs_run = 1'b1;
        repeat (20) @(negedge clk);
        xfer(1'b0, 8'h03, 8'h00, 1);
        xfer(1'b1, 8'h02, 8'h00, 1);
        xfer(1'b1, 8'h00, 8'h01, 1);
        xfer(1'b1, 8'h06, 8'h34, 1);
        xfer(1'b1, 8'h07, 8'h0A, 1);
        xfer(1'b1, 8'h02, 8'h03, 1);
        rand_traffic(1500);

        // Reset in the middle of a write: no ack, no update.
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 8'h04; bus.wb_dat_i = 8'h5A;
        #2 rst_n = 1'b0;
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 8'h04, 8'h00, 1);
        xfer(1'b0, 8'h02, 8'h00, 1);
        rand_traffic(200);

        vs_run = 1'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wb_video_regs.md
WB_VIDEO_REGS -- requirements
Module: wb_video_regs

Interface
REQ-001 SHALL have parameter VERSION, default 8'h03, value returned by the VERSION register.
REQ-002 SHALL have parameter DEFAULT_MODE, default 2'd3 (text mode), reset pattern mode.
REQ-003 SHALL have parameter CURSOR_W, default 12, cursor character-address width, legal range 9..16.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports wb_adr_i  input  8, wb_dat_i  input  8, wb_we_i  input  1, wb_cyc_i  input  1, wb_stb_i  input  1: Wishbone slave request.
REQ-007 SHALL have ports wb_dat_o  output  8 (registered read data) and wb_ack_o  output  1 (registered acknowledge).
REQ-008 SHALL have port vsync_i  input  1  vertical sync level from video timing, synchronous to clk.
REQ-009 SHALL have ports pattern_mode_o  output  2, scroll_x_o  output  8, scroll_y_o  output  8, cursor_addr_o  output  CURSOR_W: active (displayed) register values.
REQ-010 SHALL have port irq_o  output  1  frame interrupt, level.

Function
REQ-011 Decode SHALL use wb_adr_i[3:0] only; the upper address bits are decoded by the interconnect.
REQ-012 A cycle with wb_cyc_i & wb_stb_i & !wb_ack_o SHALL be accepted; wb_ack_o SHALL be high for exactly the following cycle, which gives 1-cycle latency and no back-to-back acks.
REQ-013 Register map (R/W unless noted): 0x0 MODE[1:0]; 0x1 VERSION (RO); 0x2 CTRL {bit1 IRQ_EN, bit0 SHADOW_EN}; 0x3 STATUS {bit1 UPDATE_PENDING RO, bit0 FRAME_IRQ W1C}; 0x4 SCROLL_X; 0x5 SCROLL_Y; 0x6 CURSOR_LO = cursor[7:0]; 0x7 CURSOR_HI = cursor[CURSOR_W-1:8]; 0x8 FRAME_CNT (RO).
REQ-014 Unmapped offsets SHALL read 8'h00 and ignore writes; unused register bits SHALL read 0.
REQ-015 On a write, wb_dat_o SHALL hold its previous value.
REQ-016 MODE, SCROLL_X, SCROLL_Y, CURSOR_LO and CURSOR_HI SHALL each have a shadow copy (written and read over Wishbone) and an active copy (driven on the outputs).
REQ-017 Vsync edge SHALL be the registered condition vsync_i=1 with previous vsync_i=0.
REQ-018 When SHADOW_EN=1, a write to any shadowed register SHALL set UPDATE_PENDING.
REQ-019 When SHADOW_EN=1, on a vsync edge with UPDATE_PENDING=1, all active copies SHALL load their shadow values at once and UPDATE_PENDING SHALL clear.
REQ-020 When SHADOW_EN=0, active copies SHALL load the shadow copies every cycle (the output changes one cycle after the accepting edge) and UPDATE_PENDING SHALL be held at 0.
REQ-021 If a shadow write and a vsync edge occur in the same cycle, the commit SHALL use the pre-write shadow values and UPDATE_PENDING SHALL remain 1.
REQ-022 Each vsync edge SHALL increment FRAME_CNT modulo 256 (8'hFF to 8'h00) and set FRAME_IRQ.
REQ-023 Writing 1 to STATUS bit0 SHALL clear FRAME_IRQ; if the set and the clear occur in the same cycle, the set SHALL win.
REQ-024 irq_o SHALL equal the registered value of FRAME_IRQ & IRQ_EN.
REQ-025 A write to CTRL that sets SHADOW_EN=0 while UPDATE_PENDING=1 SHALL make the pending values take effect via REQ-020.

Reset
REQ-026 On rst_n low, wb_ack_o=0 and wb_dat_o=8'h00 SHALL hold.
REQ-027 On rst_n low, shadow and active MODE SHALL equal DEFAULT_MODE.
REQ-028 On rst_n low, scroll and cursor registers (shadow and active) SHALL be 0, FRAME_CNT=0, FRAME_IRQ=0, UPDATE_PENDING=0, irq_o=0.
REQ-029 On rst_n low, CTRL SHALL be 8'h01 (shadow on, IRQ off).
REQ-030 The previous-vsync register SHALL reset to 1 so that vsync_i high at reset release generates no edge.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction with no ack and no register update.

Verification
REQ-032 Reset, then read 0x0, 0x1, 0x2 -> 8'h03, 8'h03, 8'h01; pattern_mode_o=3; irq_o=0.
REQ-033 SHADOW_EN=1: write 0x4=8'h20 -> scroll_x_o stays 0 and STATUS reads 8'h02; after the next vsync edge scroll_x_o=8'h20 and STATUS bit1=0.
REQ-034 Write CTRL=8'h00, then write 0x0=8'h01 -> pattern_mode_o=1 one cycle after the ack with no vsync; then write 0x6=8'h34 and 0x7=8'h0A -> cursor_addr_o=12'hA34.
REQ-035 CTRL=8'h03, 256 vsync edges -> FRAME_CNT reads 8'h00 and irq_o=1; write 0x3=8'h01 -> irq_o=0; W1C coincident with a vsync edge -> irq_o stays 1.
REQ-036 Shadow write of MODE=2 in the same cycle as a vsync edge with pending MODE=1 -> pattern_mode_o=1 and UPDATE_PENDING=1; the next edge -> pattern_mode_o=2.
